load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 180 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, byte-lane steering on both
// paths, early error for illegal/misaligned requests, and a memory-side timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_f3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  // state  | meaning
  // IDLE   | ready for a request
  // ACCESS | mem_valid held, waiting for mem_ready or timeout
  // RESP   | one-cycle response pulse
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state_q, state_d;
  logic          write_q, write_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    lane_q, lane_d;
  logic          mem_valid_q, mem_valid_d;
  logic          mem_write_q, mem_write_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_wstrb_q, mem_wstrb_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_error_q, rsp_error_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          legal, misaligned;
  logic [3:0]    strb;
  logic [31:0]   wdata_rep;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic [31:0]   ld_data;

  assign req_ready = rst_n && (state_q == IDLE);

  always_comb begin
    legal      = req_write ? (req_f3 inside {3'b000, 3'b001, 3'b010})
                           : (req_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = ((req_f3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_f3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    case (req_f3[1:0])
      2'b00:   begin strb = 4'b0001 << req_addr[1:0]; wdata_rep = {4{req_wdata[7:0]}};  end
      2'b01:   begin strb = 4'b0011 << req_addr[1:0]; wdata_rep = {2{req_wdata[15:0]}}; end
      default: begin strb = 4'b1111;                  wdata_rep = req_wdata;            end
    endcase
  end

  always_comb begin
    ld_b = 8'(mem_rdata >> {lane_q, 3'b000});
    ld_h = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_data = {24'b0, ld_b};
      3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_data = {16'b0, ld_h};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    mem_valid_d = mem_valid_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          write_d = req_write;
          f3_d    = req_f3;
          lane_d  = req_addr[1:0];
          if (legal && !misaligned) begin
            state_d     = ACCESS;
            mem_valid_d = 1'b1;
            mem_write_d = req_write;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = wdata_rep;
            mem_wstrb_d = req_write ? strb : 4'b0000;
            cnt_d       = CW'(1);
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = 32'h0;
          end
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b0;
          rsp_rdata_d = write_q ? 32'h0 : ld_data;
          cnt_d       = '0;
        end else if (cnt_q >= CW'(TIMEOUT_CYCLES)) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_rdata_d = 32'h0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      f3_q        <= 3'b000;
      lane_q      <= 2'b00;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      mem_valid_q <= mem_valid_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table with a response
// scoreboard, plus hand sequences for reset behaviour.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_f3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_valid;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_f3(req_f3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;      // cycles of mem_valid before mem_ready; -1 = never
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    int          e_mv;     // expected number of mem_valid cycles
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb_q[$];
  vec_t vt[14];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int dly,
                              input logic [31:0] e_addr, input logic [3:0] e_strb,
                              input logic [31:0] e_wdata, input int e_mv,
                              input logic [31:0] e_rdata, input logic e_err);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.dly = dly;
    v.e_addr = e_addr; v.e_strb = e_strb; v.e_wdata = e_wdata; v.e_mv = e_mv;
    v.e_rdata = e_rdata; v.e_err = e_err;
    return v;
  endfunction

  task automatic do_txn(input vec_t v, input int idx);
    rsp_t r, got;
    int   mv;
    bit   done;
    @(negedge clk);
    chk($sformatf("v%0d req_ready_idle", idx), {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = v.wr; req_f3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    r.rdata = v.e_rdata; r.err = v.e_err;
    sb_q.push_back(r);
    @(posedge clk);
    #1 req_valid = 1'b0;
    mv = 0;
    done = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        req_valid = 1'b0;
        mem_ready = 1'b0;
        chk($sformatf("v%0d latency", idx), k, (v.e_mv == 0) ? 1 : v.e_mv + 1);
        chk($sformatf("v%0d mem_valid_cycles", idx), mv, v.e_mv);
        if (sb_q.size() == 0) begin
          chk($sformatf("v%0d unexpected_rsp", idx), 32'd1, 32'd0);
        end else begin
          got = sb_q.pop_front();
          chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, got.rdata);
          chk($sformatf("v%0d rsp_error", idx), {31'b0, rsp_error}, {31'b0, got.err});
        end
        done = 1'b1;
      end else begin
        if (mem_valid) begin
          mv++;
          chk($sformatf("v%0d mem_addr", idx), mem_addr, v.e_addr);
          chk($sformatf("v%0d mem_wstrb", idx), {28'b0, mem_wstrb}, {28'b0, v.e_strb});
          chk($sformatf("v%0d mem_write", idx), {31'b0, mem_write}, {31'b0, v.wr});
          if (v.wr) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_wdata);
          chk($sformatf("v%0d req_ready_busy", idx), {31'b0, req_ready}, 32'd0);
          if (mv - 1 == v.dly) begin
            mem_ready = 1'b1; mem_rdata = v.rdata;
          end else begin
            mem_ready = 1'b0; mem_rdata = $urandom;
          end
        end else begin
          mem_ready = 1'b0;
        end
        // a different legal request held while busy must be ignored
        req_valid = 1'b1; req_write = 1'b1; req_f3 = 3'b010;
        req_addr = 32'h0000_0FFC; req_wdata = 32'h55AA_55AA;
      end
    end
    if (!done) begin
      req_valid = 1'b0; mem_ready = 1'b0;
      chk($sformatf("v%0d rsp_wait_expired", idx), 32'd1, 32'd0);
      void'(sb_q.pop_front());
    end
    @(negedge clk);
    chk($sformatf("v%0d rsp_one_cycle", idx), {31'b0, rsp_valid}, 32'd0);
    chk($sformatf("v%0d mem_valid_after", idx), {31'b0, mem_valid}, 32'd0);
    chk($sformatf("v%0d req_ready_after", idx), {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    //                wr    f3      addr          wdata         rdata        dly  e_addr        e_strb   e_wdata       mv  e_rdata       err
    vt[0]  = mk(1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF_1234, 0, 32'h0000_0100, 4'b0000, 32'h0,         1,  32'hFFFF_FF80, 1'b0);
    vt[1]  = mk(1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0,         0, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 1,  32'h0,         1'b0);
    vt[2]  = mk(1'b0, 3'b010, 32'h0000_0005, 32'h0,         32'h0,         0, 32'h0,         4'b0000, 32'h0,         0,  32'h0,         1'b1);
    vt[3]  = mk(1'b0, 3'b101, 32'h0000_0002, 32'h0,         32'h9ABC_0000, 5, 32'h0000_0000, 4'b0000, 32'h0,         6,  32'h0000_9ABC, 1'b0);
    vt[4]  = mk(1'b1, 3'b010, 32'h0000_0300, 32'h1234_5678, 32'h0,        -1, 32'h0000_0300, 4'b1111, 32'h1234_5678, 16, 32'h0,         1'b1);
    vt[5]  = mk(1'b0, 3'b100, 32'h0000_0101, 32'h0,         32'h80FF_1234, 0, 32'h0000_0100, 4'b0000, 32'h0,         1,  32'h0000_0012, 1'b0);
    vt[6]  = mk(1'b0, 3'b001, 32'h0000_0000, 32'h0,         32'h1234_8001, 1, 32'h0000_0000, 4'b0000, 32'h0,         2,  32'hFFFF_8001, 1'b0);
    vt[7]  = mk(1'b1, 3'b000, 32'h0000_0007, 32'h0000_00A5, 32'h0,         0, 32'h0000_0004, 4'b1000, 32'hA5A5_A5A5, 1,  32'h0,         1'b0);
    vt[8]  = mk(1'b1, 3'b100, 32'h0000_0010, 32'h1111_1111, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         0,  32'h0,         1'b1);
    vt[9]  = mk(1'b0, 3'b011, 32'h0000_0010, 32'h0,         32'h0,         0, 32'h0,         4'b0000, 32'h0,         0,  32'h0,         1'b1);
    vt[10] = mk(1'b0, 3'b001, 32'h0000_0001, 32'h0,         32'h0,         0, 32'h0,         4'b0000, 32'h0,         0,  32'h0,         1'b1);
    vt[11] = mk(1'b0, 3'b010, 32'h0000_0008, 32'h0,         32'hCAFE_F00D, 2, 32'h0000_0008, 4'b0000, 32'h0,         3,  32'hCAFE_F00D, 1'b0);
    vt[12] = mk(1'b1, 3'b010, 32'h0000_000C, 32'h0102_0304, 32'h0,        15, 32'h0000_000C, 4'b1111, 32'h0102_0304, 16, 32'h0,         1'b0);
    vt[13] = mk(1'b1, 3'b000, 32'h0000_0001, 32'h0000_007F, 32'h0,         0, 32'h0000_0000, 4'b0010, 32'h7F7F_7F7F, 1,  32'h0,         1'b0);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    chk("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'h0);
    chk("rst rsp_error", {31'b0, rsp_error}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst release req_ready", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 14; i++) do_txn(vt[i], i);

    // reset in the middle of an access abandons it
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_f3 = 3'b010;
    req_addr = 32'h0000_0040; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid mem_valid", {31'b0, mem_valid}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid rst mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("mid rst req_ready", {31'b0, req_ready}, 32'd0);
    chk("mid rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid release req_ready", {31'b0, req_ready}, 32'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid || mem_valid) chk("abandoned stays quiet", {30'b0, rsp_valid, mem_valid}, 32'd0);
    end
    chk("post-reset mem_addr", mem_addr, 32'h0);
    chk("scoreboard drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global time limit reached: got running, expected finished");
    $fatal(1);
  end
endmodule
